tdm_mux_scanner: RTL and testbench

- Parametrised N-channel, W-bit registered multiplexer. Successor to the combinational 4-to-1 mux.
- Two modes:
  - Manual: an external select picks the channel.
  - Auto-scan: an internal dwell counter round-robins through all channels.
- Sits between multi-channel sources (sensor/switch banks) and a single shared output path, e.g. display or serial logger. Reports the active channel and a wrap pulse per full scan.

---
 rtl/tdm_mux_scanner.sv | 107 ++++++++++
 tb/tb_tdm_mux_scanner.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/tdm_mux_scanner.sv
// Registered N-channel, W-bit multiplexer with manual select and round-robin auto-scan.
// All outputs are registered; ch_out always names the channel whose data is on dout.
module tdm_mux_scanner #(
  parameter int unsigned N      = 4,
  parameter int unsigned W      = 4,
  parameter int unsigned DWELL  = 4,
  localparam int unsigned SW    = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           mode,
  input  logic [SW-1:0]  sel_in,
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   dout,
  output logic [SW-1:0]  ch_out,
  output logic           valid,
  output logic           wrap,
  output logic           sel_err
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [SW-1:0] ch_q, ch_d, ch_sel;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [W-1:0]  dout_q, dout_d, mux_data;
  logic [SW-1:0] chout_q, chout_d;
  logic          valid_q, valid_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (ch_sel == SW'(i)) mux_data = din[i*W +: W];
    end
  end

  always_comb begin
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    dout_d  = dout_q;
    chout_d = chout_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    ch_sel  = ch_q;
    if (en) begin
      valid_d = 1'b1;
      if (!mode) begin
        cnt_d  = '0;
        pend_d = 1'b0;
        if (int'(sel_in) < int'(N)) ch_sel = sel_in;
        else                        err_d  = 1'b1;
        ch_d = ch_sel;
      end else begin
        // pend_q marks that ch_q just rolled over, so this cycle is the first showing channel 0
        wrap_d = pend_q;
        pend_d = 1'b0;
        if (cnt_q == CW'(DWELL - 1)) begin
          cnt_d = '0;
          if (ch_q == SW'(N - 1)) begin
            ch_d   = '0;
            pend_d = 1'b1;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      chout_d = ch_sel;
      dout_d  = mux_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q    <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      dout_q  <= '0;
      chout_q <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dout_q  <= dout_d;
      chout_q <= chout_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign dout    = dout_q;
  assign ch_out  = chout_q;
  assign valid   = valid_q;
  assign wrap    = wrap_q;
  assign sel_err = err_q;

endmodule

// File: tb/tb_tdm_mux_scanner.sv
// Scoreboard bench: stimulus pushes expected outputs, per-DUT monitors pop them on valid.
// DUT A is N=4 (scan, freeze, mode switch); DUT B is N=3 (out-of-range select).
module tb_tdm_mux_scanner;

  typedef struct packed {
    logic [3:0] d;
    logic [1:0] ch;
    logic       wr;
    logic       er;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        en_a, mode_a, valid_a, wrap_a, err_a;
  logic [1:0]  sel_a, ch_a;
  logic [15:0] din_a;
  logic [3:0]  dout_a;

  logic        en_b, mode_b, valid_b, wrap_b, err_b;
  logic [1:0]  sel_b, ch_b;
  logic [11:0] din_b;
  logic [3:0]  dout_b;

  exp_t qa[$];
  exp_t qb[$];
  int checks   = 0;
  int failures = 0;

  tdm_mux_scanner #(.N(4), .W(4), .DWELL(2)) u_a (
    .clk(clk), .rst(rst), .en(en_a), .mode(mode_a), .sel_in(sel_a), .din(din_a),
    .dout(dout_a), .ch_out(ch_a), .valid(valid_a), .wrap(wrap_a), .sel_err(err_a)
  );

  tdm_mux_scanner #(.N(3), .W(4), .DWELL(2)) u_b (
    .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .sel_in(sel_b), .din(din_b),
    .dout(dout_b), .ch_out(ch_b), .valid(valid_b), .wrap(wrap_b), .sel_err(err_b)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (valid_a) begin
      if (qa.size() == 0) chk("A_spurious_valid", 1, 0);
      else begin
        exp_t e;
        e = qa.pop_front();
        chk("A_dout", int'(dout_a), int'(e.d));
        chk("A_ch_out", int'(ch_a), int'(e.ch));
        chk("A_wrap", int'(wrap_a), int'(e.wr));
        chk("A_sel_err", int'(err_a), int'(e.er));
      end
    end
  end

  always @(negedge clk) begin
    if (valid_b) begin
      if (qb.size() == 0) chk("B_spurious_valid", 1, 0);
      else begin
        exp_t e;
        e = qb.pop_front();
        chk("B_dout", int'(dout_b), int'(e.d));
        chk("B_ch_out", int'(ch_b), int'(e.ch));
        chk("B_wrap", int'(wrap_b), int'(e.wr));
        chk("B_sel_err", int'(err_b), int'(e.er));
      end
    end
  end

  task automatic step_a(input logic e, input logic m, input logic [1:0] s, input logic v,
                        input logic [3:0] d, input logic [1:0] c, input logic wr);
    en_a = e; mode_a = m; sel_a = s;
    if (v) qa.push_back('{d: d, ch: c, wr: wr, er: 1'b0});
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic [1:0] s, input logic [3:0] d, input logic [1:0] c,
                        input logic er);
    en_b = 1'b1; mode_b = 1'b0; sel_b = s;
    qb.push_back('{d: d, ch: c, wr: 1'b0, er: er});
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en_a = 1'b1; mode_a = 1'b1; sel_a = 2'd0; din_a = 16'hDCBA;
    en_b = 1'b0; mode_b = 1'b0; sel_b = 2'd0; din_b = 12'hCBA;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dout", int'(dout_a), 0);
    chk("reset_ch_out", int'(ch_a), 0);
    chk("reset_valid", int'(valid_a), 0);
    chk("reset_wrap", int'(wrap_a), 0);
    chk("reset_sel_err", int'(err_a), 0);
    rst = 1'b0;

    // Auto-scan, two passes of DWELL=2; wrap only on the first A of pass two.
    step_a(1, 1, 0, 1, 4'hA, 0, 0); step_a(1, 1, 0, 1, 4'hA, 0, 0);
    step_a(1, 1, 0, 1, 4'hB, 1, 0); step_a(1, 1, 0, 1, 4'hB, 1, 0);
    step_a(1, 1, 0, 1, 4'hC, 2, 0); step_a(1, 1, 0, 1, 4'hC, 2, 0);
    step_a(1, 1, 0, 1, 4'hD, 3, 0); step_a(1, 1, 0, 1, 4'hD, 3, 0);
    step_a(1, 1, 0, 1, 4'hA, 0, 1); step_a(1, 1, 0, 1, 4'hA, 0, 0);

    // Freeze after the first B: outputs hold, dwell does not count.
    step_a(1, 1, 0, 1, 4'hB, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step_a(0, 1, 0, 0, 4'h0, 0, 0);
      chk("freeze_valid", int'(valid_a), 0);
      chk("freeze_dout", int'(dout_a), 'hB);
      chk("freeze_ch_out", int'(ch_a), 1);
      chk("freeze_wrap", int'(wrap_a), 0);
    end
    step_a(1, 1, 0, 1, 4'hB, 1, 0);
    step_a(1, 1, 0, 1, 4'hC, 2, 0); step_a(1, 1, 0, 1, 4'hC, 2, 0);

    // Manual sweep.
    for (int s = 0; s < 4; s++) begin
      logic [3:0] exp_d;
      exp_d = 4'hA + 4'(s);
      step_a(1, 0, 2'(s), 1, exp_d, 2'(s), 0);
    end

    // Mode switch: land on C, scan one cycle, jump to 1 manually, resume scan from B.
    step_a(1, 0, 2, 1, 4'hC, 2, 0);
    step_a(1, 1, 0, 1, 4'hC, 2, 0);
    step_a(1, 0, 1, 1, 4'hB, 1, 0);
    step_a(1, 1, 0, 1, 4'hB, 1, 0); step_a(1, 1, 0, 1, 4'hB, 1, 0);
    step_a(1, 1, 0, 1, 4'hC, 2, 0); step_a(1, 1, 0, 1, 4'hC, 2, 0);
    step_a(1, 1, 0, 1, 4'hD, 3, 0); step_a(1, 1, 0, 1, 4'hD, 3, 0);
    step_a(1, 1, 0, 1, 4'hA, 0, 1);
    step_a(0, 1, 0, 0, 4'h0, 0, 0);

    // N=3: out-of-range select holds channel 1 and still tracks live data.
    step_b(1, 4'hB, 1, 0);
    step_b(3, 4'hB, 1, 1);
    din_b = 12'hCEA;
    step_b(3, 4'hE, 1, 1);
    step_b(2, 4'hC, 2, 0);
    step_b(0, 4'hA, 0, 0);
    en_b = 1'b0;
    @(posedge clk); #1;
    chk("B_idle_sel_err", int'(err_b), 0);

    @(negedge clk); #1;
    chk("A_queue_drained", qa.size(), 0);
    chk("B_queue_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
